// File: rtl/mc6809_eq_gen.sv
// MC6809 E/Q quadrature clock generator: divides a fast PLL clock into four
// quarter phases, with optional E-high stretching requested by slow peripherals.
module mc6809_eq_gen #(
  parameter int unsigned DIV         = 25,
  parameter int unsigned MAX_STRETCH = 40
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_mrdy_n,
  output logic o_e,
  output logic o_q,
  output logic o_e_rise,
  output logic o_e_fall,
  output logic o_stretching,
  output logic o_stretch_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH0,
    ST_PH1,
    ST_PH2,
    ST_STR,
    ST_PH3
  } state_t;

  localparam logic [7:0] TERM_CNT  = 8'(DIV - 1);
  localparam logic [7:0] MAX_STR_C = 8'(MAX_STRETCH);

  state_t     state, state_nxt;
  logic [7:0] q_cnt, q_cnt_nxt;
  logic [7:0] str_cnt, str_cnt_nxt;
  logic       err_set;
  logic       term;

  assign term = (q_cnt == TERM_CNT);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_nxt   = state;
    str_cnt_nxt = str_cnt;
    err_set     = 1'b0;

    case (state)
      ST_IDLE: if (i_run) state_nxt = ST_PH0;
      ST_PH0:  if (term) state_nxt = ST_PH1;
      ST_PH1:  if (term) state_nxt = ST_PH2;
      ST_PH2: begin
        if (term) begin
          if (!i_mrdy_n) begin
            state_nxt   = ST_STR;
            str_cnt_nxt = 8'd1;
          end else begin
            state_nxt = ST_PH3;
          end
        end
      end
      ST_STR: begin
        if (term) begin
          if (i_mrdy_n) begin
            state_nxt = ST_PH3;
          end else if (str_cnt < MAX_STR_C) begin
            str_cnt_nxt = str_cnt + 8'd1;
          end else begin
            // Peripheral never released the bus: give up and flag it.
            state_nxt = ST_PH3;
            err_set   = 1'b1;
          end
        end
      end
      ST_PH3:  if (term) state_nxt = i_run ? ST_PH0 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (state_nxt == ST_PH0 && state != ST_PH0) str_cnt_nxt = 8'd0;

    if (state == ST_IDLE || term) q_cnt_nxt = 8'd0;
    else                          q_cnt_nxt = q_cnt + 8'd1;
  end

  // Outputs are registered from the next state so they line up exactly with
  // the state register and carry no combinational path from the inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      q_cnt         <= 8'd0;
      str_cnt       <= 8'd0;
      o_e           <= 1'b0;
      o_q           <= 1'b0;
      o_e_rise      <= 1'b0;
      o_e_fall      <= 1'b0;
      o_stretching  <= 1'b0;
      o_stretch_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      q_cnt         <= q_cnt_nxt;
      str_cnt       <= str_cnt_nxt;
      o_e           <= (state_nxt == ST_PH2) || (state_nxt == ST_STR) || (state_nxt == ST_PH3);
      o_q           <= (state_nxt == ST_PH1) || (state_nxt == ST_PH2) || (state_nxt == ST_STR);
      o_e_rise      <= (state == ST_PH1) && (state_nxt == ST_PH2);
      o_e_fall      <= (state == ST_PH3) && (state_nxt != ST_PH3);
      o_stretching  <= (state_nxt == ST_STR);
      o_stretch_err <= o_stretch_err | err_set;
    end
  end

endmodule

// File: tb/tb_mc6809_eq_gen.sv
// Bench for mc6809_eq_gen: a bus-cycle position model checked every cycle,
// plus directed scenarios with hand-computed period/high/stretch figures.
module tb_mc6809_eq_gen;

  localparam int D  = 4;
  localparam int MX = 3;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b1;
  logic i_run = 1'b0;
  logic i_mrdy_n = 1'b1;
  logic o_e, o_q, o_e_rise, o_e_fall, o_stretching, o_stretch_err;

  int total = 0;
  int bad   = 0;

  mc6809_eq_gen #(.DIV(D), .MAX_STRETCH(MX)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_run        (i_run),
    .i_mrdy_n     (i_mrdy_n),
    .o_e          (o_e),
    .o_q          (o_q),
    .o_e_rise     (o_e_rise),
    .o_e_fall     (o_e_fall),
    .o_stretching (o_stretching),
    .o_stretch_err(o_stretch_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position (in i_clk cycles) inside the current bus cycle and the
  // number of stretch quarters granted so far.
  bit m_act = 1'b0;
  int m_pos = 0;
  int m_n   = 0;
  bit m_err = 1'b0;
  bit m_fall = 1'b0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_act = 1'b0; m_pos = 0; m_n = 0; m_err = 1'b0; m_fall = 1'b0;
    end else begin
      m_fall = 1'b0;
      if (!m_act) begin
        if (i_run) begin m_act = 1'b1; m_pos = 0; m_n = 0; end
      end else if (m_pos == (4 + m_n) * D - 1) begin
        m_fall = 1'b1;
        if (i_run) begin m_pos = 0; m_n = 0; end
        else m_act = 1'b0;
      end else begin
        if (m_pos == (3 + m_n) * D - 1 && !i_mrdy_n) begin
          if (m_n < MX) m_n++;
          else m_err = 1'b1;
        end
        m_pos++;
      end
    end
  end

  always @(negedge i_clk) begin
    bit ee, eq, er, es;
    ee = m_act && m_pos >= 2 * D && m_pos < (4 + m_n) * D;
    eq = m_act && m_pos >= D && m_pos < (3 + m_n) * D;
    er = m_act && m_pos == 2 * D;
    es = m_act && m_pos >= 3 * D && m_pos < (3 + m_n) * D;
    check("model_e",      int'(o_e),           int'(ee));
    check("model_q",      int'(o_q),           int'(eq));
    check("model_rise",   int'(o_e_rise),      int'(er));
    check("model_fall",   int'(o_e_fall),      int'(m_fall));
    check("model_str",    int'(o_stretching),  int'(es));
    check("model_err",    int'(o_stretch_err), int'(m_err));
  end

  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (o_e_rise) begin ok = 1'b1; return; end
    end
    check("timeout_rise", 0, 1);
  endtask

  // Measures one E period from a rise to the next rise, holding i_mrdy_n low
  // for the first low_cycles cycles of E high.
  task automatic measure(input int low_cycles, output int high, output int strc,
                         output int period, output int qlead, output int falls);
    bit ok;
    int i;
    high = 0; strc = 0; period = 0; qlead = 0; falls = 0;
    wait_rise(ok);
    if (!ok) return;
    for (i = 0; i < 200; i++) begin
      if (i > 0 && o_e_rise) break;
      i_mrdy_n = (i < low_cycles) ? 1'b0 : 1'b1;
      high   += int'(o_e);
      strc   += int'(o_stretching);
      qlead  += int'(o_q && !o_e);
      falls  += int'(o_e_fall);
      period++;
      @(negedge i_clk);
    end
    i_mrdy_n = 1'b1;
    if (i == 200) check("timeout_measure", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, st, pe, ql, fa, cnt;
    bit ok;

    #1 i_rst_n = 1'b0;
    #1;
    check("rst_e", int'(o_e), 0);
    check("rst_q", int'(o_q), 0);
    check("rst_err", int'(o_stretch_err), 0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    check("idle_e", int'(o_e), 0);
    check("idle_q", int'(o_q), 0);

    // Free run
    i_run = 1'b1;
    measure(0, hi, st, pe, ql, fa);
    check("free_period", pe, 16);
    check("free_high", hi, 8);
    check("free_qlead", ql, 4);
    check("free_falls", fa, 1);
    check("free_str", st, 0);

    // Single stretch quarter
    measure(D, hi, st, pe, ql, fa);
    check("str1_period", pe, 20);
    check("str1_high", hi, 12);
    check("str1_str", st, 4);
    check("str1_err", int'(o_stretch_err), 0);

    // Stretch held: limit reached
    measure(1000, hi, st, pe, ql, fa);
    check("strmax_period", pe, 28);
    check("strmax_high", hi, 20);
    check("strmax_str", st, 12);
    check("strmax_err", int'(o_stretch_err), 1);
    measure(0, hi, st, pe, ql, fa);
    check("after_max_period", pe, 16);
    check("err_sticky", int'(o_stretch_err), 1);

    // i_run dropped in PH1
    wait_rise(ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (o_q && !o_e) begin ok = 1'b1; break; end
    end
    check("found_ph1", int'(ok), 1);
    i_run = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge i_clk);
      if (o_e_fall) begin cnt = i; break; end
    end
    check("stop_fall_delay", cnt, 12);
    repeat (10) @(negedge i_clk);
    check("parked_e", int'(o_e), 0);
    check("parked_q", int'(o_q), 0);
    check("parked_fall", int'(o_e_fall), 0);
    i_run = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge i_clk);
      if (o_q) begin cnt = i; break; end
    end
    check("restart_q_delay", cnt, 5);

    // Reset during a stretch
    i_mrdy_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge i_clk);
      if (o_stretching) begin ok = 1'b1; break; end
    end
    check("found_str", int'(ok), 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_e", int'(o_e), 0);
    check("arst_q", int'(o_q), 0);
    check("arst_str", int'(o_stretching), 0);
    check("arst_err", int'(o_stretch_err), 0);
    check("arst_fall", int'(o_e_fall), 0);
    @(posedge i_clk); #1;
    check("arst_hold_e", int'(o_e), 0);
    check("arst_hold_fall", int'(o_e_fall), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_mrdy_n = 1'b1;
    measure(0, hi, st, pe, ql, fa);
    check("post_rst_period", pe, 16);
    check("post_rst_high", hi, 8);
    check("post_rst_err", int'(o_stretch_err), 0);

    repeat (2) @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc6809_eq_gen.md
MC6809_EQ_GEN -- requirements
Module: mc6809_eq_gen

Interface
REQ-001 Parameter DIV, default 25, i_clk cycles per quarter period (25 @ 100 MHz gives 1 MHz E); legal range 2..255.
REQ-002 Parameter MAX_STRETCH, default 40, maximum stretch quarters inserted per bus cycle; legal range 1..255.
REQ-003 i_clk  input  1  fast PLL clock; sole clock.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_run  input  1  high = generate bus cycles; low = park in IDLE at the next cycle boundary.
REQ-006 i_mrdy_n  input  1  active-low stretch request from slow peripherals; synchronous to i_clk.
REQ-007 o_e  output  1  generated 6809 E clock, registered.
REQ-008 o_q  output  1  generated 6809 Q clock, leads E by one quarter, registered.
REQ-009 o_e_rise  output  1  one-i_clk pulse coincident with the first cycle of o_e high.
REQ-010 o_e_fall  output  1  one-i_clk pulse coincident with the first cycle of o_e low after a high period.
REQ-011 o_stretching  output  1  high while a stretch quarter is in progress.
REQ-012 o_stretch_err  output  1  sticky flag: stretch limit reached; cleared only by reset.

Function
REQ-013 States: IDLE (E=0,Q=0), PH0 (E=0,Q=0), PH1 (E=0,Q=1), PH2 (E=1,Q=1), STR (E=1,Q=1), PH3 (E=1,Q=0).
REQ-014 o_e/o_q are decoded from the registered state only; no combinational path from any input to them.
REQ-015 Quarter counter counts 0..DIV-1 in every non-IDLE state; the terminal count (DIV-1) advances state and reloads 0, so each quarter lasts exactly DIV i_clk cycles.
REQ-016 IDLE: counter held at 0; if i_run=1 the next state is PH0, entered on the following edge.
REQ-017 PH0 -> PH1 -> PH2 on terminal count.
REQ-018 PH2 at terminal count: i_mrdy_n=0 -> STR (stretch count=1); else -> PH3.
REQ-019 STR at terminal count: i_mrdy_n=1 -> PH3; i_mrdy_n=0 and stretch count<MAX_STRETCH -> stay STR, stretch count+1; i_mrdy_n=0 and count=MAX_STRETCH -> PH3, set o_stretch_err.
REQ-020 i_mrdy_n is sampled only at terminal count in PH2/STR; changes elsewhere have no effect.
REQ-021 PH3 at terminal count: i_run=1 -> PH0; i_run=0 -> IDLE. i_run is sampled only at this point and in IDLE; deasserting it mid-cycle never truncates a cycle.
REQ-022 Stretch count is 8 bits, cleared on entry to PH0; never wraps.
REQ-023 Nominal cycle = 4*DIV i_clk; stretched cycle = (4+N)*DIV, N = stretch quarters.
REQ-024 o_e_rise asserts for exactly one cycle on the PH1->PH2 transition; o_e_fall for exactly one cycle on PH3->PH0 or PH3->IDLE; never both in one cycle.
REQ-025 o_stretching = 1 exactly while state is STR.
REQ-026 E high duration is a whole number of quarters, always >= 2*DIV.

Reset
REQ-027 While i_rst_n=0, all outputs 0, state IDLE, counters 0, o_stretch_err cleared, regardless of i_clk.
REQ-028 Reset assertion mid-cycle (including in STR) forces E=0,Q=0 immediately without an o_e_fall pulse.
REQ-029 After release, first PH0 cycle begins on the edge after i_run=1 is seen in IDLE.

Verification (DIV=4, MAX_STRETCH=3)
REQ-030 Free run, i_run=1, i_mrdy_n=1 -> E period 16 clk, E high 8, Q rising 4 clk before E rising, one o_e_rise/o_e_fall per period.
REQ-031 i_mrdy_n=0 for one PH2 terminal sample, then 1 -> E high 12 clk, o_stretching high 4 clk, period 20.
REQ-032 i_mrdy_n held 0 -> exactly 3 STR quarters, E high 20 clk, o_stretch_err=1 and stays 1 in subsequent cycles.
REQ-033 i_run dropped during PH1 -> cycle completes, o_e_fall pulses, then E=Q=0 held in IDLE; i_run reasserted -> PH0 next edge.
REQ-034 i_rst_n pulsed low during STR -> o_e,o_q,o_stretching,o_stretch_err=0 asynchronously, no o_e_fall; normal 16-clk cycles resume after release.
